// File: rtl/elbeth_forward_source_pkg.sv
// Shared definitions for the EX/WB forwarding register: FSM states, x0 index, defaults.
package elbeth_forward_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_DRAIN     = 2'd2
    } state_e;

    localparam logic [4:0]  RD_ZERO          = 5'd0;
    localparam int unsigned XLEN_DEF         = 32;
    localparam int unsigned LOAD_TIMEOUT_DEF = 16;

    // x0 is hard-wired zero, so a write to it is never performed nor forwarded.
    function automatic logic eff_wen(input logic w_en, input logic [4:0] rd);
        return w_en && (rd != RD_ZERO);
    endfunction

endpackage

// File: rtl/elbeth_forward_source_if.sv
// EX-side, data-memory response and hazard/writeback signals of the forwarding register.
interface elbeth_forward_source_if
    import elbeth_forward_source_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            ex_valid;
    logic [4:0]      ex_rd_addr;
    logic            ex_w_gpr_en;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_result;
    logic            flush;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rsp_data;
    logic [4:0]      exs_rd_addr;
    logic            exs_w_gpr_en;
    logic [XLEN-1:0] exs_fwd_data;
    logic            exs_fwd_valid;
    logic            load_stall;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            load_fault;

    modport master (
        output ex_valid, ex_rd_addr, ex_w_gpr_en, ex_is_load, ex_result, flush,
               dmem_rsp_valid, dmem_rsp_data,
        input  exs_rd_addr, exs_w_gpr_en, exs_fwd_data, exs_fwd_valid, load_stall,
               wb_rd_addr, wb_data, wb_we, load_fault
    );

    modport slave (
        input  ex_valid, ex_rd_addr, ex_w_gpr_en, ex_is_load, ex_result, flush,
               dmem_rsp_valid, dmem_rsp_data,
        output exs_rd_addr, exs_w_gpr_en, exs_fwd_data, exs_fwd_valid, load_stall,
               wb_rd_addr, wb_data, wb_we, load_fault
    );
endinterface

// File: rtl/elbeth_load_timer.sv
// Wait-cycle counter for an outstanding load; expire flags the last allowed cycle.
// Latency: expire is combinational from the count register; count clears on clr.
module elbeth_load_timer
    import elbeth_forward_source_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);
    localparam int unsigned CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (run) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = run && (cnt_q == CW'(LOAD_TIMEOUT - 1));

endmodule

// File: rtl/elbeth_forward_source.sv
// EX/WB forwarding register: feeds the hazard unit, holds one outstanding load, drives GPR writeback.
// Latency: ALU result visible 1 cycle after capture; load data 1 cycle after dmem_rsp_valid.
// Backpressure: load_stall freezes IF/ID/EX while a load is pending; ELBETH_LOAD_TIMEOUT_EN adds an abort timer.
module elbeth_forward_source
    import elbeth_forward_source_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
`ifdef ELBETH_LOAD_TIMEOUT_EN
   ,parameter int unsigned LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
`endif
)(
    input  logic                    clk,
    input  logic                    rst_n,
    elbeth_forward_source_if.slave  bus
);
    state_e          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            fwd_vld_q, fwd_vld_d;
    logic            stall_q, stall_d;
    logic            wb_we_q, wb_we_d;
    logic            fault_q, fault_d;
    logic            tmo;
    logic            accept;
    logic            rsp;

    assign accept = bus.ex_valid && !bus.flush;
    assign rsp    = bus.dmem_rsp_valid;

`ifdef ELBETH_LOAD_TIMEOUT_EN
    elbeth_load_timer #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) u_load_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_d != state_q),
        .run    (state_q != ST_IDLE),
        .expire (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            data_q    <= '0;
            fwd_vld_q <= 1'b0;
            stall_q   <= 1'b0;
            wb_we_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            data_q    <= data_d;
            fwd_vld_q <= fwd_vld_d;
            stall_q   <= stall_d;
            wb_we_q   <= wb_we_d;
            fault_q   <= fault_d;
        end
    end

    // A clean response beats the timer; a flush beats a simultaneous response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (accept && bus.ex_is_load) state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: begin
                if (rsp && !bus.flush) state_d = ST_IDLE;
                else if (tmo)          state_d = ST_IDLE;
                else if (bus.flush)    state_d = rsp ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN:     if (rsp || tmo) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_d      = rd_q;
        wen_d     = wen_q;
        data_d    = data_q;
        fwd_vld_d = 1'b0;
        wb_we_d   = 1'b0;
        stall_d   = stall_q;
        fault_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wen_d   = 1'b0;
                stall_d = 1'b0;
                if (accept) begin
                    rd_d  = bus.ex_rd_addr;
                    wen_d = eff_wen(bus.ex_w_gpr_en, bus.ex_rd_addr);
                    if (bus.ex_is_load) begin
                        stall_d = 1'b1;
                    end else begin
                        data_d    = bus.ex_result;
                        fwd_vld_d = 1'b1;
                        wb_we_d   = eff_wen(bus.ex_w_gpr_en, bus.ex_rd_addr);
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (rsp && !bus.flush) begin
                    data_d    = bus.dmem_rsp_data;
                    fwd_vld_d = 1'b1;
                    wb_we_d   = wen_q;
                    stall_d   = 1'b0;
                end else if (tmo) begin
                    fault_d = 1'b1;
                    wen_d   = 1'b0;
                    stall_d = 1'b0;
                end else if (bus.flush) begin
                    wen_d   = 1'b0;
                    stall_d = !rsp;
                end
            end
            ST_DRAIN: begin
                wen_d = 1'b0;
                if (rsp || tmo) stall_d = 1'b0;
                fault_d = tmo && !rsp;
            end
            default: begin
                wen_d   = 1'b0;
                stall_d = 1'b0;
            end
        endcase
    end

    assign bus.exs_rd_addr   = rd_q;
    assign bus.exs_w_gpr_en  = wen_q;
    assign bus.exs_fwd_data  = data_q;
    assign bus.exs_fwd_valid = fwd_vld_q;
    assign bus.load_stall    = stall_q;
    assign bus.wb_rd_addr    = rd_q;
    assign bus.wb_data       = data_q;
    assign bus.wb_we         = wb_we_q;
    assign bus.load_fault    = fault_q;

endmodule

// File: tb/tb_elbeth_forward_source.sv
// Randomized bench for elbeth_forward_source: per-operation expectations plus a reference register file.
module tb_elbeth_forward_source;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elbeth_forward_source_if #(.XLEN(32)) bus ();

    elbeth_forward_source #(
        .XLEN(32)
`ifdef ELBETH_LOAD_TIMEOUT_EN
       ,.LOAD_TIMEOUT(4)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int exp_wr   = 0;
    int dut_wr   = 0;
    logic [31:0] ref_rf [32];
    logic [31:0] dut_rf [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ex_valid       = 1'b0;
        bus.ex_rd_addr     = 5'd0;
        bus.ex_w_gpr_en    = 1'b0;
        bus.ex_is_load     = 1'b0;
        bus.ex_result      = 32'd0;
        bus.flush          = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rsp_data  = 32'd0;
    endtask

    // Shadow register file built only from what the DUT actually writes back.
    always @(negedge clk) begin
        if (bus.wb_we === 1'b1) begin
            dut_rf[bus.wb_rd_addr] = bus.wb_data;
            dut_wr++;
        end
    end

    task automatic do_alu(input logic [4:0] rd, input logic w, input logic [31:0] res, input logic fl);
        logic eff;
        eff = w && (rd != 5'd0) && !fl;
        drive_idle();
        bus.ex_valid    = 1'b1;
        bus.ex_rd_addr  = rd;
        bus.ex_w_gpr_en = w;
        bus.ex_result   = res;
        bus.flush       = fl;
        tick();
        drive_idle();
        chk("alu_wen", 32'(bus.exs_w_gpr_en), 32'(eff));
        chk("alu_wb_we", 32'(bus.wb_we), 32'(eff));
        chk("alu_fwd_vld", 32'(bus.exs_fwd_valid), 32'(!fl));
        chk("alu_stall", 32'(bus.load_stall), 32'd0);
        if (!fl) begin
            chk("alu_rd", 32'(bus.exs_rd_addr), 32'(rd));
            chk("alu_fwd_data", bus.exs_fwd_data, res);
        end
        if (eff) begin
            chk("alu_wb_data", bus.wb_data, res);
            ref_rf[rd] = res;
            exp_wr++;
        end
        tick();
        chk("alu_wb_once", 32'(bus.wb_we), 32'd0);
        chk("alu_idle_wen", 32'(bus.exs_w_gpr_en), 32'd0);
        chk("alu_idle_fwd", 32'(bus.exs_fwd_valid), 32'd0);
    endtask

    // d: response arrives in the d-th wait cycle; f: flush in wait cycle f (0 = none).
    task automatic do_load(input logic [4:0] rd, input logic w, input int d, input int f,
                           input logic [31:0] dat);
        logic eff;
        logic flushed;
        eff     = w && (rd != 5'd0);
        flushed = 1'b0;
        drive_idle();
        bus.ex_valid    = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.ex_rd_addr  = rd;
        bus.ex_w_gpr_en = w;
        bus.ex_result   = $urandom;
        tick();
        for (int i = 1; i <= d; i++) begin
            chk("ld_stall", 32'(bus.load_stall), 32'd1);
            chk("ld_fwd_vld", 32'(bus.exs_fwd_valid), 32'd0);
            chk("ld_wen", 32'(bus.exs_w_gpr_en), 32'(eff && !flushed));
            chk("ld_no_wb", 32'(bus.wb_we), 32'd0);
            bus.ex_valid       = 1'($urandom);
            bus.ex_is_load     = 1'($urandom);
            bus.ex_rd_addr     = 5'($urandom);
            bus.ex_w_gpr_en    = 1'b1;
            bus.ex_result      = $urandom;
            bus.flush          = (i == f);
            bus.dmem_rsp_valid = (i == d);
            bus.dmem_rsp_data  = dat;
            if (i == f) flushed = 1'b1;
            tick();
        end
        drive_idle();
        chk("ld_done_stall", 32'(bus.load_stall), 32'd0);
        chk("ld_done_wb_we", 32'(bus.wb_we), 32'(eff && !flushed));
        chk("ld_done_fwd_vld", 32'(bus.exs_fwd_valid), 32'(!flushed));
        if (!flushed) begin
            chk("ld_fwd_data", bus.exs_fwd_data, dat);
            chk("ld_wb_data", bus.wb_data, dat);
            chk("ld_wb_rd", 32'(bus.wb_rd_addr), 32'(rd));
            if (eff) begin
                ref_rf[rd] = dat;
                exp_wr++;
            end
        end else begin
            chk("ld_flush_wen", 32'(bus.exs_w_gpr_en), 32'd0);
        end
        tick();
        chk("ld_wb_once", 32'(bus.wb_we), 32'd0);
    endtask

    task automatic do_stray_rsp();
        drive_idle();
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rsp_data  = $urandom;
        tick();
        drive_idle();
        chk("stray_wb_we", 32'(bus.wb_we), 32'd0);
        chk("stray_stall", 32'(bus.load_stall), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_rf[i] = 32'd0;
            dut_rf[i] = 32'd0;
        end
        drive_idle();
        repeat (3) tick();
        chk("rst_stall", 32'(bus.load_stall), 32'd0);
        chk("rst_wen", 32'(bus.exs_w_gpr_en), 32'd0);
        chk("rst_fwd_vld", 32'(bus.exs_fwd_valid), 32'd0);
        chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst_fault", 32'(bus.load_fault), 32'd0);
        chk("rst_data", bus.exs_fwd_data, 32'd0);
        rst_n = 1'b1;
        tick();

        do_alu(5'd5, 1'b1, 32'hDEADBEEF, 1'b0);
        do_alu(5'd0, 1'b1, 32'h00001234, 1'b0);
        do_alu(5'd9, 1'b1, 32'h55AA55AA, 1'b1);
        do_load(5'd7, 1'b1, 3, 0, 32'hCAFE0001);
        do_load(5'd11, 1'b1, 3, 1, 32'h0BADF00D);
        do_load(5'd12, 1'b1, 2, 2, 32'h12345678);
        do_stray_rsp();

        // Asynchronous reset while a load is outstanding.
        drive_idle();
        bus.ex_valid    = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.ex_rd_addr  = 5'd14;
        bus.ex_w_gpr_en = 1'b1;
        tick();
        drive_idle();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.load_stall), 32'd0);
        chk("arst_wen", 32'(bus.exs_w_gpr_en), 32'd0);
        chk("arst_rd", 32'(bus.exs_rd_addr), 32'd0);
        chk("arst_wb_we", 32'(bus.wb_we), 32'd0);
        tick();
        rst_n = 1'b1;
        do_stray_rsp();

`ifdef ELBETH_LOAD_TIMEOUT_EN
        drive_idle();
        bus.ex_valid    = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.ex_rd_addr  = 5'd9;
        bus.ex_w_gpr_en = 1'b1;
        tick();
        drive_idle();
        for (int i = 1; i <= 4; i++) begin
            chk("tmo_wait_fault", 32'(bus.load_fault), 32'd0);
            chk("tmo_wait_stall", 32'(bus.load_stall), 32'd1);
            tick();
        end
        chk("tmo_fault", 32'(bus.load_fault), 32'd1);
        chk("tmo_stall", 32'(bus.load_stall), 32'd0);
        chk("tmo_wen", 32'(bus.exs_w_gpr_en), 32'd0);
        chk("tmo_wb_we", 32'(bus.wb_we), 32'd0);
        tick();
        chk("tmo_fault_pulse", 32'(bus.load_fault), 32'd0);
        do_stray_rsp();
`endif

        for (int n = 0; n < 200; n++) begin
            int kind;
            int d;
            int f;
            kind = $urandom_range(0, 5);
            if (kind <= 2) begin
                do_alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom,
                       1'($urandom_range(0, 7) == 0));
            end else if (kind <= 4) begin
                d = $urandom_range(1, 4);
                f = ($urandom_range(0, 2) == 0) ? $urandom_range(1, d) : 0;
                do_load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), d, f, $urandom);
            end else begin
                do_stray_rsp();
            end
        end

        tick();
        chk("wr_count", 32'(dut_wr), 32'(exp_wr));
        for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), dut_rf[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/elbeth_forward_source.md
Name: elbeth_forward_source

Overview:
- EX/WB-side pipeline register that produces the forwarding information consumed by the ID-stage hazard logic: exs_rd_addr, exs_w_gpr_en and the forwarded value.
- Tracks one outstanding data-memory load.
- Asserts load_stall until the load data returns, then issues a one-cycle GPR writeback.
- Sits between the ELBETH execute stage and the register file write port.

Parameters:
- XLEN, 32, datapath width.
- LOAD_TIMEOUT, 16, cycles allowed in ST_LOAD_WAIT/ST_DRAIN before abort; only used with ELBETH_LOAD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage presents a retiring instruction
- ex_rd_addr  input  5  destination register
- ex_w_gpr_en  input  1  instruction writes a GPR
- ex_is_load  input  1  instruction is a load; result arrives on dmem_rsp_*
- ex_result  input  XLEN  ALU result
- flush  input  1  kill in-flight instruction (branch/trap)
- dmem_rsp_valid  input  1  load data valid, single-cycle pulse
- dmem_rsp_data  input  XLEN  load data
- exs_rd_addr  output  5  to hazard unit
- exs_w_gpr_en  output  1  to hazard unit
- exs_fwd_data  output  XLEN  forwarded value
- exs_fwd_valid  output  1  exs_fwd_data is usable this cycle
- load_stall  output  1  freeze IF/ID/EX
- wb_rd_addr  output  5  register file write address
- wb_data  output  XLEN  register file write data
- wb_we  output  1  register file write strobe
- load_fault  output  1  one-cycle pulse on load abort (timeout)

Behaviour:
- Reset (rst_n low, asynchronous): state ST_IDLE; all outputs 0, including the timeout counter.
- Effective write enable: ex_w_gpr_en & (ex_rd_addr != `RD_ZERO); x0 is never written or forwarded.
- ST_IDLE, ex_valid & !flush & !ex_is_load:
  - Capture rd, effective write enable and ex_result.
  - Next cycle: exs_* hold the captured values, exs_fwd_valid=1, wb_we=effective write enable (single cycle). Latency is 1.
- ST_IDLE, ex_valid & !flush & ex_is_load:
  - Capture rd and write enable; exs_w_gpr_en=1 so the hazard unit still matches; exs_fwd_valid=0.
  - Go to ST_LOAD_WAIT; load_stall=1 from the next cycle.
- ST_IDLE, ex_valid & flush: nothing captured; exs_w_gpr_en=0 next cycle.
- ST_IDLE, ex_valid=0: exs_w_gpr_en and exs_fwd_valid drop to 0; wb_we=0.
- ST_LOAD_WAIT:
  - ex_valid is ignored (upstream is stalled).
  - On dmem_rsp_valid: capture dmem_rsp_data. Next cycle: exs_fwd_valid=1, wb_we=1 (one cycle), load_stall=0. Return to ST_IDLE.
- ST_LOAD_WAIT with flush and no dmem_rsp_valid in the same cycle:
  - exs_w_gpr_en=0 next cycle.
  - Go to ST_DRAIN; load_stall stays 1.
- ST_LOAD_WAIT, simultaneous flush and dmem_rsp_valid: flush wins. Data is discarded, no writeback, go to ST_IDLE.
- ST_DRAIN: wait for dmem_rsp_valid, discard the data, go to ST_IDLE. load_stall deasserts the cycle after.
- dmem_rsp_valid in ST_IDLE: ignored; no state change and no write.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- No new instruction is accepted in the same cycle a load completes. The next ex_valid is accepted in ST_IDLE.

Optional Feature:
- Macro: ELBETH_LOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ST_LOAD_WAIT or ST_DRAIN and increments each cycle in those states.
  - At LOAD_TIMEOUT-1: load_fault pulses for 1 cycle, no writeback, exs_w_gpr_en=0, load_stall=0, state ST_IDLE.
  - A late response is then ignored (it arrives in ST_IDLE).
- Undefined: no counter, load_fault tied to 0, waits indefinitely.

Decomposition:
- Shared package (elbeth_definitions.v):
  - State encodings ST_IDLE/ST_LOAD_WAIT/ST_DRAIN (2-bit).
  - Existing `RD_ZERO.
  - Default LOAD_TIMEOUT.
- One natural sub-module: elbeth_load_timer (counter plus expiry compare), instantiated only under ELBETH_LOAD_TIMEOUT_EN.

Test Plan:
- Reset mid-load: enter ST_LOAD_WAIT, pull rst_n low asynchronously -> all outputs 0 immediately, state ST_IDLE; a later dmem_rsp_valid produces no write.
- ALU write: ex_valid, rd=5, w_en=1, result=0xDEADBEEF -> next cycle exs_rd_addr=5, exs_w_gpr_en=1, exs_fwd_data=0xDEADBEEF, exs_fwd_valid=1, wb_we=1 for exactly 1 cycle.
- x0 suppression: rd=0, w_en=1, result=0x1234 -> exs_w_gpr_en=0, wb_we=0.
- Load: ex_is_load, rd=7; response 0xCAFE0001 3 cycles later -> load_stall high 3 cycles; exs_w_gpr_en=1 with exs_fwd_valid=0 throughout; cycle after response: wb_we=1, wb_data=0xCAFE0001, load_stall=0.
- Flush during load: flush 1 cycle after load issue, response 2 cycles later -> ST_DRAIN, load_stall held until the cycle after the response, wb_we never asserted.
- Timeout (macro on, LOAD_TIMEOUT=4): load with no response -> load_fault pulse 4 cycles after entry, load_stall=0, later response ignored.
